// File: rtl/serial_in_scanner_pkg.sv
// Shared FSM encoding and filter helper for the 74LV165 serial-input scanner.
package serial_in_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_COMMIT   = 3'd4
    } scan_state_e;

    localparam int MATCH_W = 8;

    function automatic logic [MATCH_W-1:0] sat_inc(input logic [MATCH_W-1:0] value,
                                                   input logic [MATCH_W-1:0] limit);
        logic [MATCH_W-1:0] result;
        if (value >= limit) result = limit;
        else                result = value + MATCH_W'(1);
        return result;
    endfunction

endpackage

// File: rtl/serial_in_scanner_tick_gen.sv
// CLK_DIV phase counter with clear; tick marks the last cycle of each phase.
module serial_in_scanner_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int PH_W = $clog2(CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

    logic [PH_W-1:0] phase_r;

    // Phase counter: held at zero while cleared, wraps every CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset || clear)          phase_r <= PH_W'(0);
        else if (phase_r == PH_LAST) phase_r <= PH_W'(0);
        else                         phase_r <= phase_r + PH_W'(1);
    end

    assign tick = (phase_r == PH_LAST);

endmodule

// File: rtl/serial_in_scanner.sv
// Scans NUM_CHAINS 74LV165 chains in parallel, filters each completed scan
// and presents the stable panel word with done/changed strobes.
module serial_in_scanner
    import serial_in_scanner_pkg::*;
#(
    parameter int NUM_CHAINS   = 5,
    parameter int CHAIN_BITS   = 16,
    parameter int CLK_DIV      = 4,
    parameter int STABLE_SCANS = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           scan_en,
    input  logic                           scan_req,
    output logic                           SH_LDn,
    output logic                           RCLK,
    input  logic [NUM_CHAINS-1:0]          QH,
    output logic [NUM_CHAINS*CHAIN_BITS-1:0] data_out,
    output logic                           scan_done,
    output logic                           data_changed,
    output logic                           busy
);
    localparam int DATA_W = NUM_CHAINS * CHAIN_BITS;
    localparam int BIT_W  = $clog2(CHAIN_BITS);
    localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(CHAIN_BITS - 1);
    localparam logic [MATCH_W-1:0] STABLE_LIM = MATCH_W'(STABLE_SCANS);

    scan_state_e state_r, state_nx;
    logic pending_r, pending_nx;
    logic sh_ldn_r, rclk_r, busy_r, scan_done_r, data_changed_r;
    logic [NUM_CHAINS-1:0] qh_r;
    logic [BIT_W-1:0] bit_idx_r;
    logic [NUM_CHAINS-1:0][CHAIN_BITS-1:0] sh_r;
    logic [DATA_W-1:0] sh_flat_s, cand_r, data_r;
    logic [MATCH_W-1:0] match_cnt_r, match_post_s;
    logic tick_s, tick_clear_s, update_s;

    // Restart the phase counter so every LOAD begins on a fresh phase.
    assign tick_clear_s = (state_r == ST_IDLE) || (state_r == ST_COMMIT);

    serial_in_scanner_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear_s),
        .tick  (tick_s)
    );

    // Next-state and one-deep request merging.
    always_comb begin
        state_nx   = state_r;
        pending_nx = pending_r;
        case (state_r)
            ST_IDLE: begin
                pending_nx = 1'b0;
                if (scan_en || scan_req || pending_r) state_nx = ST_LOAD;
                else                                  state_nx = ST_IDLE;
            end
            ST_LOAD: begin
                pending_nx = pending_r | scan_req;
                if (tick_s) state_nx = ST_SHIFT_LO;
                else        state_nx = ST_LOAD;
            end
            ST_SHIFT_LO: begin
                pending_nx = pending_r | scan_req;
                if (tick_s) state_nx = ST_SHIFT_HI;
                else        state_nx = ST_SHIFT_LO;
            end
            ST_SHIFT_HI: begin
                pending_nx = pending_r | scan_req;
                if (tick_s && (bit_idx_r == LAST_BIT)) state_nx = ST_COMMIT;
                else if (tick_s)                       state_nx = ST_SHIFT_LO;
                else                                   state_nx = ST_SHIFT_HI;
            end
            ST_COMMIT: begin
                // A held request is consumed by the follow-on scan; a new one re-arms it.
                pending_nx = scan_req;
                if (scan_en || pending_r) state_nx = ST_LOAD;
                else                      state_nx = ST_IDLE;
            end
            default: begin
                state_nx   = ST_IDLE;
                pending_nx = 1'b0;
            end
        endcase
    end

    // State register and registered chain controls derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pending_r <= 1'b0;
            sh_ldn_r  <= 1'b1;
            rclk_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nx;
            pending_r <= pending_nx;
            sh_ldn_r  <= (state_nx != ST_LOAD);
            rclk_r    <= (state_nx == ST_SHIFT_HI);
            busy_r    <= (state_nx != ST_IDLE);
        end
    end

    // Input register, bit counter and per-chain shift registers (MSB arrives first).
    always_ff @(posedge clk) begin
        if (reset) begin
            qh_r      <= '0;
            bit_idx_r <= BIT_W'(0);
            sh_r      <= '0;
        end else begin
            qh_r <= QH;
            if (state_r == ST_LOAD) bit_idx_r <= BIT_W'(0);
            else if ((state_r == ST_SHIFT_HI) && tick_s) bit_idx_r <= bit_idx_r + BIT_W'(1);
            if ((state_r == ST_SHIFT_LO) && tick_s) begin
                for (int c = 0; c < NUM_CHAINS; c++) begin
                    sh_r[c] <= {sh_r[c][CHAIN_BITS-2:0], qh_r[c]};
                end
            end
        end
    end

    assign sh_flat_s = sh_r;

    // Stability filter: count consecutive identical scans, publish once stable and different.
    always_comb begin
        match_post_s = MATCH_W'(1);
        update_s     = 1'b0;
        if (sh_flat_s == cand_r) match_post_s = sat_inc(match_cnt_r, STABLE_LIM);
        else                     match_post_s = MATCH_W'(1);
        if ((state_r == ST_COMMIT) && (match_post_s >= STABLE_LIM) && (sh_flat_s != data_r))
            update_s = 1'b1;
        else
            update_s = 1'b0;
    end

    // Filter state, published word and completion strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_r         <= '0;
            match_cnt_r    <= MATCH_W'(0);
            data_r         <= '0;
            scan_done_r    <= 1'b0;
            data_changed_r <= 1'b0;
        end else begin
            scan_done_r    <= (state_r == ST_COMMIT);
            data_changed_r <= update_s;
            if (state_r == ST_COMMIT) begin
                cand_r      <= sh_flat_s;
                match_cnt_r <= match_post_s;
            end
            if (update_s) data_r <= sh_flat_s;
        end
    end

    assign SH_LDn       = sh_ldn_r;
    assign RCLK         = rclk_r;
    assign busy         = busy_r;
    assign scan_done    = scan_done_r;
    assign data_changed = data_changed_r;
    assign data_out     = data_r;

endmodule

// File: tb/tb_serial_in_scanner.sv
// Scoreboard bench: three scanner configurations driven by behavioural 74LV165 chains.
module tb_serial_in_scanner;

    typedef struct packed { logic chg; logic [79:0] data; } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        check_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    exp_t qa[$], qb[$], qc[$];
    int a_done_cnt = 0, b_done_cnt = 0, c_done_cnt = 0;

    // DUT A: 2 chains x 8 bits, CLK_DIV 2, unfiltered
    logic a_reset, a_scan_en, a_scan_req, a_shldn, a_rclk, a_done, a_chg, a_busy;
    logic [1:0] a_qh;
    logic [15:0] a_data;
    logic [7:0] a_pre [2];
    logic [7:0] a_sr [2];
    serial_in_scanner #(.NUM_CHAINS(2), .CHAIN_BITS(8), .CLK_DIV(2), .STABLE_SCANS(1)) dut_a (
        .clk(clk), .reset(a_reset), .scan_en(a_scan_en), .scan_req(a_scan_req),
        .SH_LDn(a_shldn), .RCLK(a_rclk), .QH(a_qh), .data_out(a_data),
        .scan_done(a_done), .data_changed(a_chg), .busy(a_busy));
    always @(negedge a_shldn or posedge a_rclk)
        for (int c = 0; c < 2; c++) a_sr[c] <= a_shldn ? {a_sr[c][6:0], 1'b0} : a_pre[c];
    assign a_qh = {a_sr[1][7], a_sr[0][7]};

    // DUT B: same geometry, three-scan filter
    logic b_reset, b_scan_en, b_scan_req, b_shldn, b_rclk, b_done, b_chg, b_busy;
    logic [1:0] b_qh;
    logic [15:0] b_data;
    logic [7:0] b_pre [2];
    logic [7:0] b_sr [2];
    serial_in_scanner #(.NUM_CHAINS(2), .CHAIN_BITS(8), .CLK_DIV(2), .STABLE_SCANS(3)) dut_b (
        .clk(clk), .reset(b_reset), .scan_en(b_scan_en), .scan_req(b_scan_req),
        .SH_LDn(b_shldn), .RCLK(b_rclk), .QH(b_qh), .data_out(b_data),
        .scan_done(b_done), .data_changed(b_chg), .busy(b_busy));
    always @(negedge b_shldn or posedge b_rclk)
        for (int c = 0; c < 2; c++) b_sr[c] <= b_shldn ? {b_sr[c][6:0], 1'b0} : b_pre[c];
    assign b_qh = {b_sr[1][7], b_sr[0][7]};

    // DUT C: default parameters
    logic c_reset, c_scan_en, c_scan_req, c_shldn, c_rclk, c_done, c_chg, c_busy;
    logic [4:0] c_qh;
    logic [79:0] c_data;
    logic [15:0] c_pre [5];
    logic [15:0] c_sr [5];
    serial_in_scanner dut_c (
        .clk(clk), .reset(c_reset), .scan_en(c_scan_en), .scan_req(c_scan_req),
        .SH_LDn(c_shldn), .RCLK(c_rclk), .QH(c_qh), .data_out(c_data),
        .scan_done(c_done), .data_changed(c_chg), .busy(c_busy));
    always @(negedge c_shldn or posedge c_rclk)
        for (int c = 0; c < 5; c++) c_sr[c] <= c_shldn ? {c_sr[c][14:0], 1'b0} : c_pre[c];
    assign c_qh = {c_sr[4][15], c_sr[3][15], c_sr[2][15], c_sr[1][15], c_sr[0][15]};

    // Monitors: pop one expectation per scan_done
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_chg === 1'b1) chk("a_changed_needs_done", a_done, 1'b1);
            if (a_done === 1'b1) begin
                a_done_cnt++;
                if (qa.size() == 0) chk("a_unexpected_done", qa.size(), 1);
                else begin
                    e = qa.pop_front();
                    chk("a_data_out", a_data, e.data);
                    chk("a_data_changed", a_chg, e.chg);
                end
            end
            if (b_chg === 1'b1) chk("b_changed_needs_done", b_done, 1'b1);
            if (b_done === 1'b1) begin
                b_done_cnt++;
                if (qb.size() == 0) chk("b_unexpected_done", qb.size(), 1);
                else begin
                    e = qb.pop_front();
                    chk("b_data_out", b_data, e.data);
                    chk("b_data_changed", b_chg, e.chg);
                end
            end
            if (c_chg === 1'b1) chk("c_changed_needs_done", c_done, 1'b1);
            if (c_done === 1'b1) begin
                c_done_cnt++;
                if (qc.size() == 0) chk("c_unexpected_done", qc.size(), 1);
                else begin
                    e = qc.pop_front();
                    chk("c_data_out", c_data, e.data);
                    chk("c_data_changed", c_chg, e.chg);
                end
            end
        end
    end

    // Waveform monitor on DUT C: load width, RCLK phase widths and edge count per scan
    initial begin
        int ld_low = 0, rises = 0, hi_run = 0, lo_run = 0, scans = 0;
        logic rclk_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (c_done === 1'b1) begin
                chk("c_shldn_low_cycles", ld_low, 4);
                chk("c_rclk_rises", rises, 16);
                if (scans < 2) chk("c_load_follows_commit", c_shldn, 1'b0);
                scans++;
                ld_low = 0;
                rises  = 0;
            end
            if (c_shldn === 1'b0) ld_low++;
            if (c_rclk === 1'b1 && rclk_prev === 1'b0) begin
                rises++;
                chk("c_rclk_low_phase", lo_run, 4);
            end
            if (c_rclk === 1'b0 && rclk_prev === 1'b1) chk("c_rclk_high_phase", hi_run, 4);
            if (c_rclk === 1'b1) hi_run = (rclk_prev === 1'b1) ? hi_run + 1 : 1;
            if (c_shldn === 1'b0) lo_run = 0;
            else if (c_rclk === 1'b0) lo_run = (rclk_prev === 1'b1) ? 1 : lo_run + 1;
            rclk_prev = c_rclk;
        end
    end

    task automatic pulse_a();
        @(negedge clk) a_scan_req = 1'b1;
        @(negedge clk) a_scan_req = 1'b0;
    endtask

    // Wait for the end of a LOAD phase on DUT B (which=1) or DUT C (which=2)
    task automatic wait_load_end(input int which);
        int n = 0;
        logic prev, cur, seen;
        seen = 1'b0;
        prev = (which == 1) ? b_shldn : c_shldn;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            cur = (which == 1) ? b_shldn : c_shldn;
            if (prev === 1'b0 && cur === 1'b1) seen = 1'b1;
            prev = cur;
        end
        chk("load_end_within_budget", seen, 1'b1);
    endtask

    logic [7:0] b_seq [11] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h5A, 8'hA5,
                               8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h5A};
    logic [15:0] b_exp_data [11] = '{16'h0000, 16'h0000, 16'h3CA5, 16'h3CA5, 16'h3CA5, 16'h3CA5,
                                     16'h3CA5, 16'h3CA5, 16'h3CA5, 16'h3CA5, 16'h3C5A};
    logic b_exp_chg [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    localparam logic [79:0] C_WORD = {16'hFFFE, 16'h0F0F, 16'h8001, 16'hABCD, 16'h1234};

    initial begin
        int n, d0;
        {a_reset, b_reset, c_reset} = 3'b111;
        {a_scan_en, a_scan_req, b_scan_en, b_scan_req, c_scan_en, c_scan_req} = 6'b0;
        a_pre[0] = 8'hA5; a_pre[1] = 8'h3C;
        b_pre[0] = 8'hA5; b_pre[1] = 8'h3C;
        c_pre[0] = 16'h1234; c_pre[1] = 16'hABCD; c_pre[2] = 16'h8001;
        c_pre[3] = 16'h0F0F; c_pre[4] = 16'hFFFE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        {a_reset, b_reset, c_reset} = 3'b000;
        chk("a_reset_shldn", a_shldn, 1'b1);
        chk("a_reset_rclk", a_rclk, 1'b0);
        chk("a_reset_busy", a_busy, 1'b0);
        chk("a_reset_done", a_done, 1'b0);
        chk("a_reset_changed", a_chg, 1'b0);
        chk("a_reset_data", a_data, 16'h0000);
        chk("c_reset_data", c_data, 80'h0);

        // First scan: latency and published word
        qa.push_back({1'b1, 80'h3CA5});
        pulse_a();
        n = 1;
        while (a_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            if (a_done !== 1'b1) n++;
        end
        chk("a_scan_latency", n, 35);

        // Identical second scan: no change strobe
        repeat (2) @(negedge clk);
        qa.push_back({1'b0, 80'h3CA5});
        pulse_a();
        repeat (40) @(negedge clk);
        chk("a_idle_after_scan", a_busy, 1'b0);

        // Two extra requests while busy merge into one follow-on scan
        a_pre[0] = 8'h0F;
        qa.push_back({1'b1, 80'h3C0F});
        qa.push_back({1'b0, 80'h3C0F});
        d0 = a_done_cnt;
        pulse_a();
        repeat (5) @(negedge clk);
        pulse_a();
        repeat (5) @(negedge clk);
        pulse_a();
        repeat (150) @(negedge clk);
        chk("a_pending_scan_count", a_done_cnt - d0, 2);
        chk("a_idle_after_pending", a_busy, 1'b0);

        // Reset at cycle 10 of a scan
        pulse_a();
        repeat (9) @(negedge clk);
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        chk("a_midreset_shldn", a_shldn, 1'b1);
        chk("a_midreset_rclk", a_rclk, 1'b0);
        chk("a_midreset_busy", a_busy, 1'b0);
        chk("a_midreset_data", a_data, 16'h0000);
        d0 = a_done_cnt;
        repeat (100) @(negedge clk);
        chk("a_no_done_after_reset", a_done_cnt - d0, 0);

        // Continuous scanning with a three-scan filter
        @(negedge clk) b_scan_en = 1'b1;
        for (int k = 0; k < 11; k++) begin
            wait_load_end(1);
            qb.push_back({b_exp_chg[k], 64'h0, b_exp_data[k]});
            if (k < 10) b_pre[0] = b_seq[k + 1];
            else        b_scan_en = 1'b0;
        end
        repeat (60) @(negedge clk);
        chk("b_scan_count", b_done_cnt, 11);
        chk("b_idle_after_stop", b_busy, 1'b0);

        // Default parameters: waveform and two-scan filter
        @(negedge clk) c_scan_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_load_end(2);
            if (k == 0) qc.push_back({1'b0, 80'h0});
            else        qc.push_back({(k == 1), C_WORD});
            if (k == 2) c_scan_en = 1'b0;
        end
        repeat (160) @(negedge clk);
        chk("c_scan_count", c_done_cnt, 3);
        chk("c_idle_after_stop", c_busy, 1'b0);
        chk("queues_drained", qa.size() + qb.size() + qc.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks", pass_cnt, check_cnt);
        $fatal(1);
    end

endmodule
